// File: rtl/segdisplay_pkg.sv
// rtl/segdisplay_pkg.sv - shared glyph table and sizing helpers for the segment scanner
package segdisplay_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-high segments {a,b,c,d,e,f,g} at [6:0]; entry 0 is the last element.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  localparam int DIGIT_IDX_W_MIN = 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : DIGIT_IDX_W_MIN;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - nibble to active-low 7-segment pattern, with blanking
module seg_glyph_decode
  import segdisplay_pkg::*;
(
  input  logic [3:0] val_i,
  input  logic       hex_mode_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i && (hex_mode_i || (val_i <= 4'd9))) begin
      seg_o = ~GLYPHS[val_i];
    end
  end

endmodule

// File: rtl/segdisplay_scan.sv
// rtl/segdisplay_scan.sv - multiplexed common-anode 7-segment scanner with frame-synchronous
// value buffering, leading-zero blanking, blink and PWM brightness
module segdisplay_scan
  import segdisplay_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESC_W    = 16,
  parameter int BRIGHT_W   = 3,
  parameter int BLINK_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] vals,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic                    frame_done
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int BUF_W = 6 * NUM_DIGITS;
  localparam logic [PRESC_W-1:0]    PRESC_MAX = '1;
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIGIT0    = NUM_DIGITS'(1);

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLINK_W-1:0]    frame_q, frame_d;
  logic [BUF_W-1:0]      pend_q, pend_d, act_q, act_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  seg_dp_q, seg_dp_d;

  // Buffer layout: {blink_mask, dp, vals}.
  logic [BUF_W-1:0]        in_buf;
  logic [4*NUM_DIGITS-1:0] act_vals;
  logic [NUM_DIGITS-1:0]   act_dp, act_blink;

  assign in_buf    = {blink_mask, dp, vals};
  assign act_vals  = act_q[4*NUM_DIGITS-1:0];
  assign act_dp    = act_q[5*NUM_DIGITS-1:4*NUM_DIGITS];
  assign act_blink = act_q[6*NUM_DIGITS-1:5*NUM_DIGITS];

  assign frame_done = en && (presc_q == PRESC_MAX) && (idx_q == IDX_LAST);

  always_comb begin
    presc_d = '0;
    idx_d   = '0;
    frame_d = '0;
    if (en) begin
      presc_d = presc_q + PRESC_W'(1);
      idx_d   = idx_q;
      frame_d = frame_q;
      if (presc_q == PRESC_MAX) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      if (frame_done) begin
        frame_d = frame_q + BLINK_W'(1);
      end
    end
  end

  // New values reach the active set only at a frame boundary, or at once while scanning is off.
  always_comb begin
    pend_d       = pend_q;
    act_d        = act_q;
    pend_valid_d = pend_valid_q;
    if (load && (frame_done || !en)) begin
      act_d        = in_buf;
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_d       = in_buf;
      pend_valid_d = 1'b1;
    end else if (frame_done && pend_valid_q) begin
      act_d        = pend_q;
      pend_valid_d = 1'b0;
    end
  end

  logic [NUM_DIGITS-1:0] lz_hide;
  logic                  lz_run;

  always_comb begin
    lz_hide = '0;
    lz_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run     = lz_run && (act_vals[4*i +: 4] == 4'd0);
      lz_hide[i] = lz_blank && (i != 0) && lz_run;
    end
  end

  logic [3:0] cur_val;
  logic       cur_blink_hide;
  logic       cur_blank;
  logic       anode_on;
  logic [6:0] glyph_seg;

  assign cur_val        = act_vals[{idx_q, 2'b00} +: 4];
  assign cur_blink_hide = act_blink[idx_q] && frame_q[BLINK_W-1];
  assign cur_blank      = lz_hide[idx_q] || cur_blink_hide;
  // Slot cycle 0 stays dark so the previous digit's cathodes never ghost onto the new anode.
  assign anode_on       = en && (presc_q != '0) &&
                          (presc_q[PRESC_W-1 -: BRIGHT_W] <= brightness);

  seg_glyph_decode u_glyph (
    .val_i      (cur_val),
    .hex_mode_i (hex_mode),
    .blank_i    (cur_blank),
    .seg_o      (glyph_seg)
  );

  always_comb begin
    an_d     = '1;
    seg_d    = SEG_BLANK;
    seg_dp_d = 1'b1;
    if (anode_on) begin
      an_d     = ~(DIGIT0 << idx_q);
      seg_d    = glyph_seg;
      seg_dp_d = ~(act_dp[idx_q] && !cur_blink_hide);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      pend_q       <= '0;
      act_q        <= '0;
      pend_valid_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      seg_dp_q     <= 1'b1;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign seg_dp = seg_dp_q;

endmodule

// File: tb/tb_segdisplay_scan.sv
// tb/tb_segdisplay_scan.sv - randomized and directed checks of segdisplay_scan against a frame-level model
module tb_segdisplay_scan;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] vals;
  logic [3:0]  dp;
  logic [3:0]  blink_mask;
  logic        hex_mode;
  logic        lz_blank;
  logic [1:0]  brightness;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        seg_dp;
  logic        frame_done;

  segdisplay_scan #(
    .NUM_DIGITS (4),
    .PRESC_W    (4),
    .BRIGHT_W   (2),
    .BLINK_W    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .vals       (vals),
    .dp         (dp),
    .blink_mask (blink_mask),
    .hex_mode   (hex_mode),
    .lz_blank   (lz_blank),
    .brightness (brightness),
    .an         (an),
    .seg        (seg),
    .seg_dp     (seg_dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low patterns, {a..g} at [6:0].
  logic [6:0] glyph_al [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: position within the 64-cycle frame, frame number, active/pending {blink,dp,vals}.
  int          m_t;
  int          m_frame;
  logic [23:0] m_act;
  logic [23:0] m_pend;
  bit          m_pv;
  int          last_t;
  bit          last_fd;

  task automatic model_reset();
    m_t = 0; m_frame = 0; m_act = '0; m_pend = '0; m_pv = 0;
  endtask

  task automatic tick();
    int         p, d;
    logic [3:0] v, one, e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fd;
    bit         on, bh, lzh;
    logic [23:0] in_buf;
    #1;
    p    = m_t % 16;
    d    = m_t / 16;
    e_fd = en && (m_t == 63);
    n_cmp++;
    if (frame_done !== e_fd) begin
      n_fail++;
      $display("FAIL frame_done t=%0d got %b want %b", m_t, frame_done, e_fd);
    end
    on    = en && (p != 0) && ((p / 4) <= brightness);
    v     = m_act[4*d +: 4];
    bh    = m_act[20+d] && (m_frame >= 2);
    lzh   = lz_blank && (d != 0) && ((m_act[15:0] >> (4*d)) == 16'h0);
    one   = 4'b0001;
    e_an  = on ? ~(one << d) : 4'hF;
    e_seg = 7'h7F;
    if (on && !bh && !lzh && (hex_mode || v < 10)) e_seg = glyph_al[v];
    e_dp  = !(on && m_act[16+d] && !bh);
    in_buf = {blink_mask, dp, vals};
    if (load && (e_fd || !en)) begin
      m_act = in_buf; m_pv = 0;
    end else if (load) begin
      m_pend = in_buf; m_pv = 1;
    end else if (e_fd && m_pv) begin
      m_act = m_pend; m_pv = 0;
    end
    last_t  = m_t;
    last_fd = e_fd;
    if (en) begin
      if (e_fd) m_frame = (m_frame + 1) % 4;
      m_t = (m_t + 1) % 64;
    end else begin
      m_t = 0; m_frame = 0;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (an !== e_an) begin
      n_fail++;
      $display("FAIL an t=%0d got %h want %h", last_t, an, e_an);
    end
    n_cmp++;
    if (seg !== e_seg) begin
      n_fail++;
      $display("FAIL seg t=%0d got %h want %h", last_t, seg, e_seg);
    end
    n_cmp++;
    if (seg_dp !== e_dp) begin
      n_fail++;
      $display("FAIL seg_dp t=%0d got %b want %b", last_t, seg_dp, e_dp);
    end
  endtask

  task automatic run_to(input int tgt);
    int guard = 0;
    while (m_t != tgt && guard < 130) begin tick(); guard++; end
    n_cmp++;
    if (m_t != tgt) begin n_fail++; $display("FAIL run_to got %0d want %0d", m_t, tgt); end
  endtask

  task automatic run_to_last(input int tgt);
    int guard = 0;
    tick();
    while (last_t != tgt && guard < 130) begin tick(); guard++; end
    n_cmp++;
    if (last_t != tgt) begin n_fail++; $display("FAIL run_to_last got %0d want %0d", last_t, tgt); end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    vals = v; load = 1'b1; tick(); load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; vals = '0; dp = '0; blink_mask = '0;
    hex_mode = 1'b0; lz_blank = 1'b0; brightness = 2'd3;
    #12;
    n_cmp++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an got %h want f", an); end
    n_cmp++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h want 7f", seg); end
    n_cmp++; if (seg_dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b want 1", seg_dp); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b want 0", frame_done); end
    model_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_digits();
    logic [3:0] want_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] want_seg [4] = '{7'h4C, 7'h06, 7'h12, 7'h4F};
    int fd_cnt = 0;
    en = 1'b1;
    pulse_load(16'h1234);
    run_to(0);
    for (int k = 0; k < 192; k++) begin
      tick();
      if (last_fd) fd_cnt++;
      if (last_t % 16 == 8) begin
        n_cmp++;
        if (an !== want_an[last_t/16] || seg !== want_seg[last_t/16]) begin
          n_fail++;
          $display("FAIL digits slot=%0d got an=%h seg=%h want an=%h seg=%h", last_t/16, an, seg,
                   want_an[last_t/16], want_seg[last_t/16]);
        end
      end
    end
    n_cmp++;
    if (fd_cnt != 3) begin n_fail++; $display("FAIL frame_count got %0d want 3", fd_cnt); end
  endtask

  task automatic test_lz_hex();
    logic [6:0] want_dec [4] = '{7'h24, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] want_hex [4] = '{7'h24, 7'h08, 7'h7F, 7'h7F};
    hex_mode = 1'b0; lz_blank = 1'b1;
    pulse_load(16'h00A5);
    run_to(0);
    for (int k = 0; k < 64; k++) begin
      tick();
      if (last_t % 16 == 8) begin
        n_cmp++;
        if (seg !== want_dec[last_t/16]) begin
          n_fail++;
          $display("FAIL lz_dec slot=%0d got %h want %h", last_t/16, seg, want_dec[last_t/16]);
        end
      end
    end
    hex_mode = 1'b1;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (last_t % 16 == 8) begin
        n_cmp++;
        if (seg !== want_hex[last_t/16]) begin
          n_fail++;
          $display("FAIL lz_hex slot=%0d got %h want %h", last_t/16, seg, want_hex[last_t/16]);
        end
      end
    end
    lz_blank = 1'b0; hex_mode = 1'b0;
  endtask

  task automatic test_brightness();
    int lit;
    int want [4] = '{12, 28, 44, 60};
    for (int b = 0; b < 4; b++) begin
      brightness = 2'(b);
      run_to(0);
      lit = 0;
      for (int k = 0; k < 64; k++) begin
        tick();
        if (an !== 4'hF) lit++;
      end
      n_cmp++;
      if (lit != want[b]) begin
        n_fail++;
        $display("FAIL bright b=%0d got %0d want %0d", b, lit, want[b]);
      end
    end
  endtask

  task automatic test_back_to_back();
    brightness = 2'd3;
    run_to(20);
    pulse_load(16'h1111);
    run_to(40);
    pulse_load(16'h2222);
    run_to_last(56);
    n_cmp++;
    if (seg !== 7'h01) begin n_fail++; $display("FAIL db_old got %h want 01", seg); end
    run_to(0);
    run_to_last(8);
    n_cmp++;
    if (seg !== 7'h12) begin n_fail++; $display("FAIL db_new got %h want 12", seg); end
    run_to(63);
    pulse_load(16'h3333);
    run_to_last(8);
    n_cmp++;
    if (seg !== 7'h06) begin n_fail++; $display("FAIL db_fd_load got %h want 06", seg); end
  endtask

  task automatic test_blink();
    logic [6:0] want_seg;
    dp = 4'b0001; blink_mask = 4'b0001;
    pulse_load(16'h1234);
    run_to(0);
    for (int f = 0; f < 8; f++) begin
      run_to_last(8);
      want_seg = (m_frame >= 2) ? 7'h7F : 7'h4C;
      n_cmp++;
      if (seg !== want_seg || seg_dp !== (m_frame >= 2)) begin
        n_fail++;
        $display("FAIL blink frame=%0d got seg=%h dp=%b want seg=%h", m_frame, seg, seg_dp, want_seg);
      end
    end
    dp = '0; blink_mask = '0;
  endtask

  task automatic test_en_drop();
    run_to(37);
    en = 1'b0;
    tick();
    n_cmp++;
    if (an !== 4'hF || seg !== 7'h7F || seg_dp !== 1'b1) begin
      n_fail++;
      $display("FAIL en_drop got an=%h seg=%h dp=%b want f/7f/1", an, seg, seg_dp);
    end
    pulse_load(16'h9876);
    en = 1'b1;
    run_to_last(8);
    n_cmp++;
    if (an !== 4'hE || seg !== 7'h20) begin
      n_fail++;
      $display("FAIL en_restart got an=%h seg=%h want e/20", an, seg);
    end
  endtask

  task automatic test_mid_reset();
    brightness = 2'd3;
    run_to(63);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (an !== 4'hF || seg !== 7'h7F || seg_dp !== 1'b1 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got an=%h seg=%h dp=%b fd=%b want f/7f/1/0", an, seg, seg_dp, frame_done);
    end
    model_reset();
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 1600; k++) begin
      load = ($urandom_range(0, 29) == 0);
      if (load) begin
        for (int j = 0; j < 4; j++) vals[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        dp = 4'($urandom);
        blink_mask = 4'($urandom);
      end
      if ($urandom_range(0, 79) == 0) hex_mode = ~hex_mode;
      if ($urandom_range(0, 79) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 99) == 0) brightness = 2'($urandom);
      if ($urandom_range(0, 249) == 0) en = ~en;
      if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_digits();
    test_lz_hex();
    test_brightness();
    test_back_to_back();
    test_blink();
    test_en_drop();
    test_mid_reset();
    en = 1'b1;
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
